// File: rtl/limb_initiator.sv
// Bus-master end of the 8-bit LIMB bus: turns one valid/ready request at a time
// into a LIMB read or write cycle with setup, strobe, wait-stretch and hold phases.
module limb_initiator #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic       ckin,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_cmd,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       irq,
    output logic [7:0] limb_d_out,
    output logic       limb_d_oe,
    input  logic [7:0] limb_d_in,
    output logic       limb_cmd,
    output logic       limb_ncs,
    output logic       limb_nwe,
    output logic       limb_nrd,
    input  logic       limb_nwait,
    input  logic       limb_nreq,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(WAIT_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       wr_q, wr_d;
    logic       cmd_q, cmd_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] cap_q, cap_d;
    logic       tout_q, tout_d;
    logic       nwait_s1_q, nwait_s1_d, nwait_s2_q, nwait_s2_d;
    logic       nreq_s1_q, nreq_s1_d, nreq_s2_q, nreq_s2_d;
    logic       ncs_q, ncs_d, nwe_q, nwe_d, nrd_q, nrd_d;
    logic       cmd_out_q, cmd_out_d, d_oe_q, d_oe_d;
    logic [7:0] d_out_q, d_out_d;
    logic       rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       busy_d, strobe_d;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high only in IDLE outside reset.
    assign req_ready = (state_q == ST_IDLE) && !reset;

    // Registered bus outputs are decoded from the next state so they change
    // on the same edge as the state itself.
    assign busy_d   = (state_d != ST_IDLE);
    assign strobe_d = (state_d == ST_STROBE) || (state_d == ST_WAIT);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wait_cnt_d    = wait_cnt_q;
        wr_d          = wr_q;
        cmd_d         = cmd_q;
        wdata_d       = wdata_q;
        cap_d         = cap_q;
        tout_d        = tout_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        nwait_s1_d    = limb_nwait;
        nwait_s2_d    = nwait_s1_q;
        nreq_s1_d     = limb_nreq;
        nreq_s2_d     = nreq_s1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    cmd_d   = req_cmd;
                    wdata_d = req_wdata;
                    cap_d   = 8'h00;
                    tout_d  = 1'b0;
                    cnt_d   = SETUP_LOAD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LOAD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!nwait_s2_q) begin
                    wait_cnt_d = 8'd0;
                    state_d    = ST_WAIT;
                end else begin
                    cap_d   = wr_q ? 8'h00 : limb_d_in;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (nwait_s2_q) begin
                    cap_d   = wr_q ? 8'h00 : limb_d_in;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    tout_d  = 1'b1;
                    cap_d   = 8'h00;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = cap_q;
                    rsp_timeout_d = tout_q;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ncs_d     = !busy_d;
        nwe_d     = !(strobe_d && wr_d);
        nrd_d     = !(strobe_d && !wr_d);
        d_oe_d    = busy_d && wr_d;
        d_out_d   = (busy_d && wr_d) ? wdata_d : 8'h00;
        cmd_out_d = busy_d ? cmd_d : 1'b0;
    end

    always_ff @(posedge ckin) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            wait_cnt_q    <= 8'd0;
            wr_q          <= 1'b0;
            cmd_q         <= 1'b0;
            wdata_q       <= 8'h00;
            cap_q         <= 8'h00;
            tout_q        <= 1'b0;
            nwait_s1_q    <= 1'b1;
            nwait_s2_q    <= 1'b1;
            nreq_s1_q     <= 1'b1;
            nreq_s2_q     <= 1'b1;
            ncs_q         <= 1'b1;
            nwe_q         <= 1'b1;
            nrd_q         <= 1'b1;
            cmd_out_q     <= 1'b0;
            d_oe_q        <= 1'b0;
            d_out_q       <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            wr_q          <= wr_d;
            cmd_q         <= cmd_d;
            wdata_q       <= wdata_d;
            cap_q         <= cap_d;
            tout_q        <= tout_d;
            nwait_s1_q    <= nwait_s1_d;
            nwait_s2_q    <= nwait_s2_d;
            nreq_s1_q     <= nreq_s1_d;
            nreq_s2_q     <= nreq_s2_d;
            ncs_q         <= ncs_d;
            nwe_q         <= nwe_d;
            nrd_q         <= nrd_d;
            cmd_out_q     <= cmd_out_d;
            d_oe_q        <= d_oe_d;
            d_out_q       <= d_out_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign limb_ncs    = ncs_q;
    assign limb_nwe    = nwe_q;
    assign limb_nrd    = nrd_q;
    assign limb_cmd    = cmd_out_q;
    assign limb_d_oe   = d_oe_q;
    assign limb_d_out  = d_out_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign irq         = !nreq_s2_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_limb_initiator.sv
// Directed bench for limb_initiator: per-cycle bus observation plus a response
// scoreboard holding {timeout, rdata} for every request issued.
module tb_limb_initiator;

    logic       ckin = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_write, req_cmd;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_timeout, irq;
    logic [7:0] rsp_rdata;
    logic [7:0] limb_d_out, limb_d_in;
    logic       limb_d_oe, limb_cmd, limb_ncs, limb_nwe, limb_nrd;
    logic       limb_nwait, limb_nreq;
    logic [2:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];

    // per-transaction observations
    int ncs_n, ncs_first, ncs_last, nwe_n, nrd_n, stb_first, stb_last;
    int rsp_cyc, rel_cyc, bad_cmd, bad_oe, bad_dout, bad_strobe;
    logic rdy_at_rsp;

    limb_initiator dut (
        .ckin(ckin), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_cmd(req_cmd), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .irq(irq), .limb_d_out(limb_d_out), .limb_d_oe(limb_d_oe),
        .limb_d_in(limb_d_in), .limb_cmd(limb_cmd), .limb_ncs(limb_ncs),
        .limb_nwe(limb_nwe), .limb_nrd(limb_nrd), .limb_nwait(limb_nwait),
        .limb_nreq(limb_nreq), .dbg_state(dbg_state)
    );

    // clock
    initial forever #5 ckin = ~ckin;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every response pulse pops one expected {timeout, rdata}
    always @(negedge ckin) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected rsp_valid", 32'd1, 32'd0);
            end else begin
                chk("rsp {timeout,rdata}", {23'd0, rsp_timeout, rsp_rdata}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // Issues a request at the current negedge and watches the bus until the
    // response pulse. mode 1 stretches with nwait for 10 cycles.
    task automatic run_txn(input logic wr, input logic cmd, input logic [7:0] wd,
                           input logic hold_valid, input int mode, input int budget,
                           input logic [8:0] exp);
        logic strobe;
        exp_q.push_back(exp);
        req_valid = 1'b1; req_write = wr; req_cmd = cmd; req_wdata = wd;
        ncs_n = 0; ncs_first = 0; ncs_last = 0; nwe_n = 0; nrd_n = 0;
        stb_first = 0; stb_last = 0; rsp_cyc = 0; rel_cyc = 0;
        bad_cmd = 0; bad_oe = 0; bad_dout = 0; bad_strobe = 0; rdy_at_rsp = 1'b0;
        @(posedge ckin);
        for (int c = 1; c <= budget; c++) begin
            @(negedge ckin);
            if (c == 1 && !hold_valid) req_valid = 1'b0;
            if (limb_ncs === 1'b0) begin
                ncs_n++;
                if (ncs_first == 0) ncs_first = c;
                ncs_last = c;
                if (limb_cmd !== cmd) bad_cmd++;
                if (limb_d_oe !== wr) bad_oe++;
                if (wr && limb_d_out !== wd) bad_dout++;
            end
            strobe = !(limb_nwe && limb_nrd);
            if (!limb_nwe && !limb_nrd) bad_strobe++;
            if (strobe && limb_ncs) bad_strobe++;
            if (!limb_nwe) nwe_n++;
            if (!limb_nrd) nrd_n++;
            if (strobe) begin
                if (stb_first == 0) stb_first = c;
                stb_last = c;
            end
            if (mode == 1) begin
                if (strobe && stb_first == c) limb_nwait = 1'b0;
                if (stb_first != 0 && c == stb_first + 10) begin
                    limb_d_in = 8'h5A;
                    limb_nwait = 1'b1;
                    rel_cyc = c;
                end
            end
            if (rsp_valid === 1'b1) begin
                rsp_cyc = c;
                rdy_at_rsp = req_ready;
                break;
            end
        end
    endtask

    initial begin
        logic [9:0] irq_hist;
        int rsp_seen;
        int d;

        // reset with a pending request
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_cmd = 1'b1; req_wdata = 8'hFF;
        limb_d_in = 8'h00; limb_nwait = 1'b1; limb_nreq = 1'b1;
        repeat (3) @(posedge ckin);
        @(negedge ckin);
        chk("reset ncs", limb_ncs, 1);
        chk("reset nwe", limb_nwe, 1);
        chk("reset nrd", limb_nrd, 1);
        chk("reset cmd", limb_cmd, 0);
        chk("reset d_oe", limb_d_oe, 0);
        chk("reset d_out", limb_d_out, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_timeout", rsp_timeout, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset irq", irq, 0);
        chk("reset req_ready", req_ready, 0);
        chk("reset state", dbg_state, 0);
        req_valid = 1'b0; reset = 1'b0;
        @(negedge ckin);
        chk("post-reset req_ready", req_ready, 1);
        chk("post-reset ncs", limb_ncs, 1);
        chk("post-reset d_oe", limb_d_oe, 0);

        // plain write
        run_txn(1'b1, 1'b0, 8'hA5, 1'b0, 0, 20, 9'h000);
        chk("wr rsp cycle", rsp_cyc, 6);
        chk("wr ncs low count", ncs_n, 5);
        chk("wr ncs first", ncs_first, 1);
        chk("wr ncs last", ncs_last, 5);
        chk("wr nwe count", nwe_n, 3);
        chk("wr strobe first", stb_first, 2);
        chk("wr strobe last", stb_last, 4);
        chk("wr nrd count", nrd_n, 0);
        chk("wr d_oe", bad_oe, 0);
        chk("wr d_out", bad_dout, 0);
        chk("wr cmd", bad_cmd, 0);
        chk("wr strobe rules", bad_strobe, 0);

        // plain read
        limb_d_in = 8'h3C;
        run_txn(1'b0, 1'b1, 8'h11, 1'b0, 0, 20, {1'b0, 8'h3C});
        chk("rd rsp cycle", rsp_cyc, 6);
        chk("rd nrd count", nrd_n, 3);
        chk("rd strobe first", stb_first, 2);
        chk("rd nwe count", nwe_n, 0);
        chk("rd d_oe low", bad_oe, 0);
        chk("rd cmd", bad_cmd, 0);
        chk("rd strobe rules", bad_strobe, 0);

        // stretched read
        limb_d_in = 8'hC3;
        run_txn(1'b0, 1'b0, 8'h00, 1'b0, 1, 60, {1'b0, 8'h5A});
        d = stb_last + 1 - rel_cyc;
        chk("stretch nrd rise latency 2..3", (d >= 2 && d <= 3), 1);
        chk("stretch nrd held", (nrd_n >= 12), 1);
        chk("stretch rsp after hold", rsp_cyc, stb_last + 2);
        chk("stretch strobe rules", bad_strobe, 0);

        // timeout
        limb_d_in = 8'h77; limb_nwait = 1'b0;
        run_txn(1'b0, 1'b0, 8'h00, 1'b0, 0, 400, {1'b1, 8'h00});
        chk("timeout strobe length", nrd_n, 258);
        chk("timeout rsp cycle", rsp_cyc, 261);
        limb_nwait = 1'b1;
        run_txn(1'b1, 1'b1, 8'h96, 1'b0, 0, 20, 9'h000);
        chk("post-timeout wr rsp cycle", rsp_cyc, 6);
        chk("post-timeout wr nwe count", nwe_n, 3);
        chk("post-timeout d_out", bad_dout, 0);

        // back-to-back writes with req_valid held
        run_txn(1'b1, 1'b0, 8'h01, 1'b1, 0, 20, 9'h000);
        chk("b2b#1 rsp cycle", rsp_cyc, 6);
        chk("b2b#1 ready at rsp", rdy_at_rsp, 1);
        run_txn(1'b1, 1'b1, 8'h02, 1'b1, 0, 20, 9'h000);
        chk("b2b#2 ncs first", ncs_first, 1);
        chk("b2b#2 ncs last", ncs_last, 5);
        chk("b2b#2 rsp cycle", rsp_cyc, 6);
        chk("b2b#2 d_out", bad_dout, 0);
        run_txn(1'b1, 1'b0, 8'h03, 1'b0, 0, 20, 9'h000);
        chk("b2b#3 ncs first", ncs_first, 1);
        chk("b2b#3 rsp cycle", rsp_cyc, 6);
        chk("b2b#3 d_out", bad_dout, 0);

        // reset during the strobe phase aborts without a response
        @(negedge ckin);
        req_valid = 1'b1; req_write = 1'b1; req_cmd = 1'b1; req_wdata = 8'h5C;
        @(posedge ckin);
        @(negedge ckin); req_valid = 1'b0;
        @(negedge ckin);
        chk("abort pre strobe low", limb_nwe, 0);
        reset = 1'b1;
        @(negedge ckin);
        chk("abort nwe", limb_nwe, 1);
        chk("abort nrd", limb_nrd, 1);
        chk("abort ncs", limb_ncs, 1);
        chk("abort d_oe", limb_d_oe, 0);
        chk("abort state", dbg_state, 0);
        reset = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ckin);
            if (rsp_valid === 1'b1) rsp_seen++;
        end
        chk("abort no response", rsp_seen, 0);

        // irq follows nreq two cycles later
        irq_hist = '0;
        for (int j = 0; j < 10; j++) begin
            @(negedge ckin);
            irq_hist[j] = irq;
            limb_nreq = (j < 4) ? 1'b0 : 1'b1;
        end
        chk("irq pulse shape", irq_hist, 10'h03C);

        repeat (4) @(negedge ckin);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
